// File: rtl/ej32_pkg.sv
// Shared types and constants for the eJ32 image-ROM fetch front end.
package ej32_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_e;

    // Byte count minus one; three bits cover words up to 64 bits.
    localparam int FETCH_LEN_W = 3;
    typedef logic [FETCH_LEN_W-1:0] fetch_len_t;

    // Java order: the first byte fetched lands in the most significant byte.
    localparam bit EJ32_BIG_ENDIAN = 1'b1;

endpackage

// File: rtl/ej32_brom.sv
// Byte-wide synchronous ROM with registered output and clock enable.
module ej32_brom #(
   parameter int    ROM_SZ    = 8192,
   parameter string INIT_FILE = "",
   localparam int   MSZ       = $clog2(ROM_SZ)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clk_en,
   input  logic [MSZ-1:0] addr,
   output logic [7:0]     dout
);

   logic [7:0] mem [ROM_SZ];

   // Registered read, frozen while the enable is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout <= '0;
      end else if (clk_en) begin
         dout <= mem[addr];
      end
   end

endmodule

// File: rtl/ej32_rom_fetch.sv
// Multi-channel word-assembling fetch front end for the eJ32 image ROM.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; round-robin grant and operand latch
// READ  | issuing one byte address per cycle, shifting returned bytes
// DONE  | last byte returning; word extended into rd_d, ack pulsed
module ej32_rom_fetch
    import ej32_pkg::*;
#(
    parameter int    ROM_SZ    = 8192,
    parameter int    DW        = 32,
    parameter int    NCH       = 2,
    parameter string INIT_FILE = "",
    localparam int   MSZ       = $clog2(ROM_SZ),
    localparam int   NB        = DW / 8,
    localparam int   LW        = $clog2(NB)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    req,
    input  logic [NCH*32-1:0] addr,
    input  logic [NCH*LW-1:0] len,
    input  logic [NCH-1:0]    sx,
    output logic [NCH-1:0]    ack,
    output logic [DW-1:0]     rd_d,
    output logic              busy,
    output logic              rom_en
);

    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

    fetch_state_e   state_q, state_d;
    logic [GW-1:0]  rr_q, gnt_q, win, idx;
    logic           any_req;
    logic [31:0]    addr_ch [NCH];
    logic [LW-1:0]  len_ch  [NCH];
    logic [31:0]    addr_sel;
    logic [LW-1:0]  len_sel;
    fetch_len_t     len_c;
    logic [MSZ-1:0] addr_q;
    fetch_len_t     cnt_q;
    fetch_len_t     nm1_q;
    logic           sx_q;
    logic           vld_q;
    logic [7:0]     rom_d;
    logic [DW-1:0]  acc_q, acc_next, ordered, keep, word_fin;
    logic           sign;
    logic           unused_addr_hi;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign addr_ch[g] = addr[32*g +: 32];
        assign len_ch[g]  = len[LW*g +: LW];
    end

    // Round-robin pick: scan from the channel after the last winner.
    always_comb begin
        any_req = 1'b0;
        win     = rr_q;
        idx     = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = GW'((int'(rr_q) + i) % NCH);
            if (req[idx]) begin
                any_req = 1'b1;
                win     = idx;
            end
        end
    end

    // Operands of the winning channel, with the byte count clamped to the word.
    always_comb begin
        addr_sel = addr_ch[win];
        len_sel  = len_ch[win];
        len_c    = (int'(len_sel) > NB - 1) ? fetch_len_t'(NB - 1) : fetch_len_t'(len_sel);
    end

    // Only the low MSZ address bits reach the ROM; the rest wrap away.
    assign unused_addr_hi = ^addr_sel[31:MSZ];

    // Next-state logic and ROM enable.
    always_comb begin
        state_d = state_q;
        rom_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) state_d = ST_READ;
            end
            ST_READ: begin
                rom_en = 1'b1;
                if (cnt_q == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                rom_en  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shift in the returning byte, then order, mask and extend to DW.
    always_comb begin
        acc_next = EJ32_BIG_ENDIAN ? {acc_q[DW-9:0], rom_d} : {rom_d, acc_q[DW-1:8]};
        ordered  = EJ32_BIG_ENDIAN ? acc_next : (acc_next >> (8 * (NB - 1 - int'(nm1_q))));
        keep     = '0;
        sign     = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if (b <= int'(nm1_q)) keep[8*b +: 8] = 8'hFF;
            if (b == int'(nm1_q)) sign = ordered[8*b+7];
        end
        word_fin = (sx_q && sign) ? (ordered | ~keep) : (ordered & keep);
    end

    // Grant latch, address/count stepping, byte accumulation and result/ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q   <= '0;
            gnt_q  <= '0;
            addr_q <= '0;
            cnt_q  <= '0;
            nm1_q  <= '0;
            sx_q   <= 1'b0;
            vld_q  <= 1'b0;
            acc_q  <= '0;
            rd_d   <= '0;
            ack    <= '0;
        end else begin
            ack   <= '0;
            vld_q <= (state_q == ST_READ);
            if (vld_q) acc_q <= acc_next;
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        gnt_q  <= win;
                        rr_q   <= (int'(win) == NCH - 1) ? '0 : win + 1'b1;
                        addr_q <= addr_sel[MSZ-1:0];
                        cnt_q  <= len_c;
                        nm1_q  <= len_c;
                        sx_q   <= sx[win];
                        acc_q  <= '0;
                    end
                end
                ST_READ: begin
                    addr_q <= addr_q + 1'b1;
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                ST_DONE: begin
                    rd_d       <= word_fin;
                    ack[gnt_q] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE) || (|ack);

    ej32_brom #(
        .ROM_SZ    (ROM_SZ),
        .INIT_FILE (INIT_FILE)
    ) u_rom (
        .clk    (clk),
        .rst    (rst),
        .clk_en (rom_en),
        .addr   (addr_q),
        .dout   (rom_d)
    );

endmodule
